mastermind_round_sequencer: RTL and testbench

Game-level controller for the Mastermind board. Sequences secret-code entry, guess entry and per-round scoring, and tracks the guess budget and win/lose outcome. Scoring is done by an external peg-scoring unit over a req/ack handshake. Outputs drive the HEX displays and game-status LEDs.

---
 rtl/mastermind_round_sequencer.sv | 127 ++++++++++++
 tb/tb_mastermind_round_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mastermind_round_sequencer.sv
// Mastermind game controller: code entry, guess entry, scoring handshake and win/lose tracking.
// Optional build macro MM_CODE_HIDE_EN masks the code output until the game has ended.
module mastermind_round_sequencer #(
    parameter int unsigned MAX_GUESSES = 8,
    parameter int unsigned DIGIT_W     = 3
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 load_btn,
    input  logic                 new_game,
    input  logic [DIGIT_W-1:0]   data_in,
    output logic                 score_req,
    input  logic                 score_ack,
    input  logic [2:0]           red_in,
    input  logic [2:0]           white_in,
    output logic [4*DIGIT_W-1:0] code,
    output logic [4*DIGIT_W-1:0] guess,
    output logic [1:0]           digit_idx,
    output logic [2:0]           state,
    output logic [3:0]           guess_count,
    output logic [2:0]           red_out,
    output logic [2:0]           white_out,
    output logic                 win,
    output logic                 lose
);

    typedef enum logic [2:0] {
        StCodeEntry  = 3'd0,
        StGuessEntry = 3'd1,
        StScore      = 3'd2,
        StWin        = 3'd3,
        StLose       = 3'd4
    } state_e;

    localparam logic [3:0] MaxCount = 4'(MAX_GUESSES);

    state_e               state_q;
    logic [4*DIGIT_W-1:0] code_q;
    logic [4*DIGIT_W-1:0] guess_q;
    logic [1:0]           idx_q;
    logic [3:0]           count_q;
    logic [2:0]           red_q;
    logic [2:0]           white_q;
    logic                 req_q;
    logic                 win_q;
    logic                 lose_q;
    logic                 load_q;

    logic       load_evt;
    logic [3:0] count_inc;

    assign load_evt  = load_btn & ~load_q;
    assign count_inc = count_q + 4'd1;

    always_ff @(posedge clk) begin
        // Button history tracks the pin in every state, independent of new_game.
        load_q <= resetn ? load_btn : 1'b0;
        if (!resetn || new_game) begin
            state_q <= StCodeEntry;
            code_q  <= '0;
            guess_q <= '0;
            idx_q   <= '0;
            count_q <= '0;
            red_q   <= '0;
            white_q <= '0;
            req_q   <= 1'b0;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StCodeEntry: begin
                    if (load_evt) begin
                        code_q[32'(idx_q) * DIGIT_W +: DIGIT_W] <= data_in;
                        idx_q <= idx_q + 2'd1;
                        if (idx_q == 2'd3) state_q <= StGuessEntry;
                    end
                end
                StGuessEntry: begin
                    if (load_evt) begin
                        guess_q[32'(idx_q) * DIGIT_W +: DIGIT_W] <= data_in;
                        idx_q <= idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            state_q <= StScore;
                            req_q   <= 1'b1;
                        end
                    end
                end
                StScore: begin
                    if (score_ack && req_q) begin
                        red_q   <= red_in;
                        white_q <= white_in;
                        count_q <= count_inc;
                        req_q   <= 1'b0;
                        if (red_in == 3'd4) begin
                            state_q <= StWin;
                            win_q   <= 1'b1;
                        end else if (count_inc == MaxCount) begin
                            state_q <= StLose;
                            lose_q  <= 1'b1;
                        end else begin
                            state_q <= StGuessEntry;
                        end
                    end
                end
                StWin, StLose: ;
                default: state_q <= StCodeEntry;
            endcase
        end
    end

`ifdef MM_CODE_HIDE_EN
    assign code = (state_q == StWin || state_q == StLose) ? code_q : '0;
`else
    assign code = code_q;
`endif

    assign score_req   = req_q;
    assign guess       = guess_q;
    assign digit_idx   = idx_q;
    assign state       = state_q;
    assign guess_count = count_q;
    assign red_out     = red_q;
    assign white_out   = white_q;
    assign win         = win_q;
    assign lose        = lose_q;

endmodule

// File: tb/tb_mastermind_round_sequencer.sv
// Self-checking bench for mastermind_round_sequencer: round tables with a scoring scoreboard,
// plus hand-written sequences for button hold, stray acks, new_game and reset corners.
module tb_mastermind_round_sequencer;

    localparam int unsigned DW  = 3;
    localparam int unsigned MAX = 8;
`ifdef MM_CODE_HIDE_EN
    localparam bit Hide = 1'b1;
`else
    localparam bit Hide = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetn, load_btn, new_game, score_ack, score_req, win, lose;
    logic [DW-1:0] data_in;
    logic [2:0]    red_in, white_in, red_out, white_out, state;
    logic [11:0]   code, guess;
    logic [1:0]    digit_idx;
    logic [3:0]    guess_count;

    mastermind_round_sequencer #(.MAX_GUESSES(MAX), .DIGIT_W(DW)) dut (
        .clk(clk), .resetn(resetn), .load_btn(load_btn), .new_game(new_game),
        .data_in(data_in), .score_req(score_req), .score_ack(score_ack),
        .red_in(red_in), .white_in(white_in), .code(code), .guess(guess),
        .digit_idx(digit_idx), .state(state), .guess_count(guess_count),
        .red_out(red_out), .white_out(white_out), .win(win), .lose(lose)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  red;
        logic [2:0]  white;
        int          delay;
        logic [11:0] gs;
        logic [2:0]  st;
        logic [3:0]  cnt;
        logic        win;
        logic        lose;
    } round_t;

    round_t game_a[8];
    round_t game_b[8];
    round_t exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [11:0] Secret = 12'hE5D;  // digits 5,3,1,7

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] exp_code(input logic [2:0] st, input logic [11:0] val);
        return (Hide && st != 3'd3 && st != 3'd4) ? 12'h000 : val;
    endfunction

    // Reference outcome of a round given its ack values and 1-based round number.
    function automatic round_t mk(input logic [2:0] r, input logic [2:0] w, input int d,
                                  input logic [11:0] gs, input int n);
        round_t x;
        x.red = r; x.white = w; x.delay = d; x.gs = gs; x.cnt = 4'(n);
        x.win  = (r == 3'd4);
        x.lose = !x.win && (n == int'(MAX));
        x.st   = x.win ? 3'd3 : (x.lose ? 3'd4 : 3'd1);
        return x;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        resetn = 1'b0; tick(); tick(); resetn = 1'b1;
    endtask

    task automatic do_new_game();
        new_game = 1'b1; tick(); new_game = 1'b0;
    endtask

    task automatic load_digit(input logic [DW-1:0] d);
        data_in = d; load_btn = 1'b1; tick(); load_btn = 1'b0; tick();
    endtask

    task automatic enter4(input logic [11:0] v);
        for (int i = 0; i < 4; i++) load_digit(v[3*i +: 3]);
    endtask

    task automatic wait_req();
        int k = 0;
        while (score_req !== 1'b1 && k < 10) begin tick(); k++; end
        check("score_req_rise", {31'd0, score_req}, 32'd1);
    endtask

    task automatic compare_pop(input string tag);
        round_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check({tag, "_req_drop"}, {31'd0, score_req}, 32'd0);
        check({tag, "_red"}, {29'd0, red_out}, {29'd0, e.red});
        check({tag, "_white"}, {29'd0, white_out}, {29'd0, e.white});
        check({tag, "_count"}, {28'd0, guess_count}, {28'd0, e.cnt});
        check({tag, "_state"}, {29'd0, state}, {29'd0, e.st});
        check({tag, "_win"}, {31'd0, win}, {31'd0, e.win});
        check({tag, "_lose"}, {31'd0, lose}, {31'd0, e.lose});
    endtask

    task automatic play_round(input string tag, input round_t r);
        enter4(r.gs);
        check({tag, "_guess"}, {20'd0, guess}, {20'd0, r.gs});
        check({tag, "_code_hidden"}, {20'd0, code}, {20'd0, exp_code(3'd2, Secret)});
        wait_req();
        repeat (r.delay) tick();
        check({tag, "_req_held"}, {31'd0, score_req}, 32'd1);
        score_ack = 1'b1; red_in = r.red; white_in = r.white;
        exp_q.push_back(r);
        tick();
        score_ack = 1'b0; red_in = 3'd0; white_in = 3'd0;
        compare_pop(tag);
    endtask

    initial begin
        for (int i = 0; i < 8; i++)
            game_a[i] = mk(3'd1, 3'd2, i % 4, 12'(i * 291 + 7), i + 1);
        game_b[0] = mk(3'd0, 3'd0, 0, 12'h123, 1);
        game_b[1] = mk(3'd2, 3'd1, 1, 12'h456, 2);
        game_b[2] = mk(3'd5, 3'd3, 2, 12'h789, 3);  // >4 captured unchanged, no win
        game_b[3] = mk(3'd3, 3'd1, 3, 12'hABC, 4);
        game_b[4] = mk(3'd1, 3'd1, 0, 12'hDEF, 5);
        game_b[5] = mk(3'd0, 3'd4, 1, 12'h0F0, 6);
        game_b[6] = mk(3'd7, 3'd0, 2, 12'hF0F, 7);
        game_b[7] = mk(3'd4, 3'd0, 3, Secret, 8);   // win beats lose on final round

        resetn = 1'b0; load_btn = 1'b0; new_game = 1'b0; data_in = '0;
        score_ack = 1'b0; red_in = '0; white_in = '0;
        do_reset();
        check("rst_state", {29'd0, state}, 32'd0);
        check("rst_code", {20'd0, code}, 32'd0);
        check("rst_guess", {20'd0, guess}, 32'd0);
        check("rst_idx", {30'd0, digit_idx}, 32'd0);
        check("rst_count", {28'd0, guess_count}, 32'd0);
        check("rst_red_white", {26'd0, red_out, white_out}, 32'd0);
        check("rst_req_win_lose", {29'd0, score_req, win, lose}, 32'd0);

        // Held button writes exactly one slot.
        data_in = 3'd6; load_btn = 1'b1;
        repeat (20) tick();
        load_btn = 1'b0; tick();
        check("hold_idx", {30'd0, digit_idx}, 32'd1);
        check("hold_code", {20'd0, code}, {20'd0, exp_code(3'd0, 12'h006)});
        check("hold_state", {29'd0, state}, 32'd0);

        do_reset();
        enter4(Secret);
        check("code_entry_code", {20'd0, code}, {20'd0, exp_code(3'd1, Secret)});
        check("code_entry_state", {29'd0, state}, 32'd1);
        check("code_entry_idx", {30'd0, digit_idx}, 32'd0);

        // Stray ack outside SCORE is ignored.
        score_ack = 1'b1; red_in = 3'd4; tick(); score_ack = 1'b0; red_in = 3'd0;
        check("stray_ack_state", {29'd0, state}, 32'd1);
        check("stray_ack_count_red", {25'd0, guess_count, red_out}, 32'd0);

        play_round("win1", mk(3'd4, 3'd0, 3, Secret, 1));
        check("win1_code_shown", {20'd0, code}, {20'd0, Secret});
        load_digit(3'd2);
        check("win1_load_ignored", {20'd0, guess}, {20'd0, Secret});
        check("win1_hold_state", {29'd0, state}, 32'd3);

        do_new_game();
        check("ng_state", {29'd0, state}, 32'd0);
        check("ng_win_code", {19'd0, win, code}, 32'd0);

        enter4(Secret);
        for (int i = 0; i < 8; i++) play_round($sformatf("lose_r%0d", i + 1), game_a[i]);
        check("lose_code_shown", {20'd0, code}, {20'd0, Secret});

        do_new_game();
        enter4(Secret);
        for (int i = 0; i < 8; i++) play_round($sformatf("winlast_r%0d", i + 1), game_b[i]);

        // new_game coinciding with score_ack wins.
        do_new_game();
        enter4(Secret);
        play_round("ng_r1", mk(3'd1, 3'd3, 0, 12'h111, 1));
        enter4(12'h222);
        wait_req();
        tick();
        new_game = 1'b1; score_ack = 1'b1; red_in = 3'd4; white_in = 3'd2;
        tick();
        new_game = 1'b0; score_ack = 1'b0; red_in = 3'd0; white_in = 3'd0;
        check("ng_ack_state", {29'd0, state}, 32'd0);
        check("ng_ack_count", {28'd0, guess_count}, 32'd0);
        check("ng_ack_red", {29'd0, red_out}, 32'd0);
        check("ng_ack_req_win", {30'd0, score_req, win}, 32'd0);

        // Reset while a request is pending abandons it.
        enter4(Secret);
        enter4(12'h333);
        wait_req();
        resetn = 1'b0; tick(); resetn = 1'b1;
        check("rst_score_req", {31'd0, score_req}, 32'd0);
        check("rst_score_state", {29'd0, state}, 32'd0);

        check("sb_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
